// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - channel index sequencer with programmable dwell for scan decoders
module scan_sequencer #(
  parameter int NUM_CH  = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               enable,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         index,
  output logic               indexValid,
  output logic               stepStrobe,
  output logic               scanDone,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic               mode_q, mode_d;
  logic [3:0]         index_d;
  logic               valid_d, strobe_d, done_d;

  // State and all outputs are flops; reset clears everything regardless of inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      index      <= 4'd0;
      indexValid <= 1'b0;
      stepStrobe <= 1'b0;
      scanDone   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      mode_q     <= mode_d;
      index      <= index_d;
      indexValid <= valid_d;
      stepStrobe <= strobe_d;
      scanDone   <= done_d;
    end
  end

  // Next-state logic; dwell is loaded on every index entry so a new value
  // applies from the following index, while the current one keeps its period.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mode_d   = mode_q;
    index_d  = index;
    valid_d  = indexValid;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        index_d = 4'd0;
        valid_d = 1'b0;
        if (start && !stop) begin
          state_d  = SCAN;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          cnt_d    = dwell;
          mode_d   = mode;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          index_d = 4'd0;
          valid_d = 1'b0;
        end else if (enable) begin
          if (cnt != '0) begin
            cnt_d = cnt - DWELL_W'(1);
          end else if (index < LAST_IDX) begin
            index_d  = index + 4'd1;
            strobe_d = 1'b1;
            cnt_d    = dwell;
          end else if (!mode_q) begin
            index_d  = 4'd0;
            strobe_d = 1'b1;
            cnt_d    = dwell;
          end else begin
            state_d = IDLE;
            index_d = 4'd0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = 4'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, enable, mode;
  logic [15:0] dwell;
  logic [3:0]  index_a, index_b;
  logic        valid_a, valid_b, strobe_a, strobe_b, done_a, done_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.NUM_CH(16), .DWELL_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .enable(enable),
    .mode(mode), .dwell(dwell), .index(index_a), .indexValid(valid_a),
    .stepStrobe(strobe_a), .scanDone(done_a), .busy(busy_a)
  );

  scan_sequencer #(.NUM_CH(4), .DWELL_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .enable(enable),
    .mode(mode), .dwell(dwell), .index(index_b), .indexValid(valid_b),
    .stepStrobe(strobe_b), .scanDone(done_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b1; mode = 1'b0; dwell = 16'd0;
    tick();
    check("rst_index", index_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_strobe", strobe_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy_a, 0);

    // continuous 16-channel scan, dwell=2: each index held three cycles
    dwell = 16'd2; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 48; k++) begin
      check($sformatf("cont_idx_%0d", k), index_a, (k / 3) % 16);
      check($sformatf("cont_stb_%0d", k), strobe_a, (k % 3) == 0);
      check($sformatf("cont_val_%0d", k), valid_a, 1);
      if (k < 48) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop1_busy", busy_a, 0);

    // single-pass 4-channel scan, dwell=0
    dwell = 16'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sp_idx_%0d", k), index_b, k);
      check($sformatf("sp_stb_%0d", k), strobe_b, 1);
      check($sformatf("sp_busy_%0d", k), busy_b, 1);
      check($sformatf("sp_done_%0d", k), done_b, 0);
      tick();
    end
    check("sp_done_pulse", done_b, 1);
    check("sp_busy_end", busy_b, 0);
    check("sp_valid_end", valid_b, 0);
    check("sp_idx_end", index_b, 0);
    tick();
    check("sp_done_once", done_b, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // pause mid-dwell on index 7, dwell=3
    dwell = 16'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 29; k++) tick();
    check("pause_pre_idx", index_a, 7);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("pause_idx_%0d", k), index_a, 7);
      check($sformatf("pause_stb_%0d", k), strobe_a, 0);
    end
    enable = 1'b1;
    tick();
    check("resume_idx_a", index_a, 7);
    tick();
    check("resume_idx_b", index_a, 7);
    tick();
    check("resume_idx_8", index_a, 8);
    check("resume_stb_8", strobe_a, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // stop and start together at index 5
    dwell = 16'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("ss_pre_idx", index_a, 5);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("ss_busy", busy_a, 0);
    check("ss_idx", index_a, 0);
    check("ss_valid", valid_a, 0);
    check("ss_done", done_a, 0);
    tick();
    check("ss_done_after", done_a, 0);
    check("ss_busy_after", busy_a, 0);

    // reset mid-scan at index 9, then restart
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("mr_pre_idx", index_a, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_idx", index_a, 0);
    check("mr_valid", valid_a, 0);
    check("mr_strobe", strobe_a, 0);
    check("mr_busy", busy_a, 0);
    check("mr_done", done_a, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mr_restart_idx", index_a, 0);
    check("mr_restart_stb", strobe_a, 1);
    check("mr_restart_busy", busy_a, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // dwell change from 1 to 4 while index 2 is active
    dwell = 16'd1; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("dw_idx2_entry", index_a, 2);
    check("dw_idx2_stb", strobe_a, 1);
    dwell = 16'd4;
    tick();
    check("dw_idx2_hold", index_a, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("dw_idx3_%0d", k), index_a, 3);
      check($sformatf("dw_stb3_%0d", k), strobe_a, k == 0);
    end
    tick();
    check("dw_idx4", index_a, 4);
    check("dw_stb4", strobe_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
